// File: rtl/cga_text_fetch.sv
// CGA text-mode fetch and serialiser.
// Fetches the character/attribute pair for each cell from VRAM, then the glyph
// row from the font ROM, and shifts out 8 IRGB pixels per cell. The next cell
// is prefetched while the current one is on screen.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   pixel_en                     pixel clock enable (never on consecutive clks)
//   line_start, start_addr       scanline start pulse and first VRAM address
//   row_addr                     glyph scanline within the character row
//   display_enable               active display area
//   blink_en, blink_phase        attr[7] blink vs. intensity, blink timer
//   pixel_addr/read/data         VRAM read port (data valid 1 clk later)
//   font_addr/font_data          font ROM port (data valid 1 clk later)
//   pix_color                    registered IRGB pixel
//   underrun                     sticky: a cell load found no prefetched data
module cga_text_fetch #(
   parameter int unsigned FONT_ROWS = 8
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            pixel_en,
   input  logic                            line_start,
   input  logic [13:0]                     start_addr,
   input  logic [$clog2(FONT_ROWS)-1:0]    row_addr,
   input  logic                            display_enable,
   input  logic                            blink_en,
   input  logic                            blink_phase,
   output logic [18:0]                     pixel_addr,
   output logic                            pixel_read,
   input  logic [7:0]                      pixel_data,
   output logic [7+$clog2(FONT_ROWS):0]    font_addr,
   input  logic [7:0]                      font_data,
   output logic [3:0]                      pix_color,
   output logic                            underrun
);

   localparam int unsigned ADDR_W  = 14;
   localparam int unsigned VADDR_W = 19;
   localparam int unsigned ROW_W   = $clog2(FONT_ROWS);
   localparam int unsigned FONT_W  = 8 + ROW_W;
   localparam int unsigned CNT_W   = 3;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] F_CHAR = 3'd1;
   localparam logic [2:0] F_ATTR = 3'd2;
   localparam logic [2:0] F_FONT = 3'd3;
   localparam logic [2:0] F_CAP  = 3'd4;
   localparam logic [2:0] READY  = 3'd5;

   logic [2:0]        state, state_nxt;
   logic [ADDR_W-1:0] fetch_addr;
   logic [7:0]        char_reg, attr_reg;
   logic [7:0]        pre_bits, pre_attr;
   logic [7:0]        shifter, cell_attr;
   logic [CNT_W-1:0]  bit_cnt;
   logic              shifter_valid;
   logic              load_c;

   // Colour of one pixel given its glyph bit and the cell attribute.
   function automatic logic [3:0] cell_colour(input logic px, input logic [7:0] attr,
                                              input logic ben, input logic bph);
      logic [3:0] bg;
      bg = ben ? {1'b0, attr[6:4]} : attr[7:4];
      if (ben && attr[7] && bph) return bg;
      return px ? attr[3:0] : bg;
   endfunction

   // A prefetched cell is consumed at the start of each displayed character.
   assign load_c = pixel_en && display_enable && !line_start &&
                   (bit_cnt == '0) && (state == READY);

   // Fetch FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next state and memory-port decode.
   always_comb begin
      state_nxt  = state;
      pixel_addr = '0;
      pixel_read = 1'b0;
      font_addr  = '0;
      case (state)
         F_CHAR: begin
            pixel_addr = VADDR_W'(fetch_addr);
            pixel_read = 1'b1;
            state_nxt  = F_ATTR;
         end
         F_ATTR: begin
            pixel_addr = VADDR_W'(fetch_addr + ADDR_W'(1));
            pixel_read = 1'b1;
            state_nxt  = F_FONT;
         end
         F_FONT: begin
            font_addr = FONT_W'({char_reg, row_addr});
            state_nxt = F_CAP;
         end
         F_CAP: begin
            font_addr = FONT_W'({char_reg, row_addr});
            state_nxt = READY;
         end
         READY:   if (load_c) state_nxt = F_CHAR;
         default: state_nxt = state;
      endcase
      if (line_start) state_nxt = F_CHAR;
   end

   // Fetch captures, shifter and pixel output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_addr    <= '0;
         char_reg      <= '0;
         attr_reg      <= '0;
         pre_bits      <= '0;
         pre_attr      <= '0;
         shifter       <= '0;
         cell_attr     <= '0;
         bit_cnt       <= '0;
         shifter_valid <= 1'b0;
         pix_color     <= '0;
         underrun      <= 1'b0;
      end else begin
         if (state == F_ATTR) char_reg <= pixel_data;
         if (state == F_FONT) attr_reg <= pixel_data;
         if (state == F_CAP) begin
            pre_bits <= font_data;
            pre_attr <= attr_reg;
         end

         if (line_start) begin
            fetch_addr    <= start_addr;
            bit_cnt       <= '0;
            shifter_valid <= 1'b0;
            if (pixel_en) pix_color <= '0;
         end else if (pixel_en) begin
            if (!display_enable) begin
               pix_color <= '0;
            end else if (bit_cnt == '0) begin
               if (state == READY) begin
                  shifter       <= {pre_bits[6:0], 1'b0};
                  cell_attr     <= pre_attr;
                  shifter_valid <= 1'b1;
                  pix_color     <= cell_colour(pre_bits[7], pre_attr, blink_en, blink_phase);
                  bit_cnt       <= CNT_W'(1);
                  fetch_addr    <= fetch_addr + ADDR_W'(2);
               end else begin
                  // No data ready; an idle block (no line yet) is not an underrun.
                  pix_color <= '0;
                  if (state != IDLE) underrun <= 1'b1;
               end
            end else begin
               pix_color <= shifter_valid ?
                            cell_colour(shifter[7], cell_attr, blink_en, blink_phase) : 4'd0;
               shifter   <= {shifter[6:0], 1'b0};
               bit_cnt   <= bit_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_cga_text_fetch.sv
// Self-checking bench for cga_text_fetch: directed cases plus random cells
// checked against a per-pixel reference computed from the colour rules.
module tb_cga_text_fetch;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        pixel_en;
   logic        line_start;
   logic [13:0] start_addr;
   logic [2:0]  row_addr;
   logic        display_enable;
   logic        blink_en;
   logic        blink_phase;
   logic [18:0] pixel_addr;
   logic        pixel_read;
   logic [7:0]  pixel_data;
   logic [10:0] font_addr;
   logic [7:0]  font_data;
   logic [3:0]  pix_color;
   logic        underrun;

   logic [7:0]  vram [16384];
   logic [7:0]  font [2048];
   logic [18:0] rd_q [$];
   logic        rec_on = 1'b0;
   logic        ur_exp = 1'b0;
   int          checks = 0;
   int          errors = 0;

   cga_text_fetch #(.FONT_ROWS(8)) dut (
      .clk(clk), .reset_n(reset_n), .pixel_en(pixel_en), .line_start(line_start),
      .start_addr(start_addr), .row_addr(row_addr), .display_enable(display_enable),
      .blink_en(blink_en), .blink_phase(blink_phase), .pixel_addr(pixel_addr),
      .pixel_read(pixel_read), .pixel_data(pixel_data), .font_addr(font_addr),
      .font_data(font_data), .pix_color(pix_color), .underrun(underrun)
   );

   always #5 clk = ~clk;

   // Memories with one clock of read latency.
   always @(posedge clk) begin
      pixel_data <= vram[pixel_addr[13:0]];
      font_data  <= font[font_addr];
   end

   always @(posedge clk) if (rec_on && pixel_read) rd_q.push_back(pixel_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One pixel_en pulse followed by an idle clock; colour must hold across it.
   task automatic pix(input logic de, output logic [3:0] c);
      pixel_en = 1'b1;
      display_enable = de;
      tick();
      c = pix_color;
      pixel_en = 1'b0;
      tick();
      check("pix_hold", 32'(pix_color), 32'(c));
   endtask

   task automatic line(input logic [13:0] a);
      line_start = 1'b1;
      start_addr = a;
      tick();
      line_start = 1'b0;
   endtask

   // Expected colour of pixel b of the cell at VRAM address a.
   function automatic logic [3:0] ref_pix(input int a, input int row, input int b,
                                          input logic ben, input logic ph);
      logic [7:0] ch, at, g;
      logic [3:0] fg, bg;
      ch = vram[a % 16384];
      at = vram[(a + 1) % 16384];
      g  = font[int'(ch) * 8 + row];
      fg = at[3:0];
      bg = ben ? {1'b0, at[6:4]} : at[7:4];
      if (ben && at[7] && ph) return bg;
      return g[7 - b] ? fg : bg;
   endfunction

   task automatic run_line(input int start, input int n);
      logic [3:0] c;
      line(14'(start));
      repeat (4) tick();
      for (int k = 0; k < n; k++)
         for (int b = 0; b < 8; b++) begin
            pix(1'b1, c);
            check("line_pix", 32'(c),
                  32'(ref_pix(start + 2 * k, int'(row_addr), b, blink_en, blink_phase)));
         end
      check("line_underrun", 32'(underrun), 32'(ur_exp));
   endtask

   // One cell with expected nibbles packed leftmost pixel first.
   task automatic directed_cell(input string tag, input logic [13:0] a, input logic [31:0] exp);
      logic [3:0] c;
      line(a);
      repeat (4) tick();
      for (int b = 0; b < 8; b++) begin
         pix(1'b1, c);
         check(tag, 32'(c), 32'(4'(exp >> (28 - 4 * b))));
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_addr"}, 32'(pixel_addr), 32'h0);
      check({tag, "_read"}, 32'(pixel_read), 32'h0);
      check({tag, "_font"}, 32'(font_addr), 32'h0);
      check({tag, "_col"}, 32'(pix_color), 32'h0);
      check({tag, "_ur"}, 32'(underrun), 32'h0);
   endtask

   initial begin
      logic [3:0] c;
      logic [31:0] seq;
      reset_n = 1'b0; pixel_en = 1'b0; line_start = 1'b0; start_addr = '0;
      row_addr = '0; display_enable = 1'b0; blink_en = 1'b0; blink_phase = 1'b0;
      for (int i = 0; i < 16384; i++) vram[i] = 8'($urandom);
      for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);

      // Reset state
      repeat (3) tick();
      check_zero("reset");
      reset_n = 1'b1;
      tick();
      check_zero("post_reset");

      // First character: fetch addresses and 'A' glyph row
      vram[0] = 8'h41; vram[1] = 8'h1E; font[{8'h41, 3'd2}] = 8'h3C;
      row_addr = 3'd2;
      line(14'h0000);
      check("fc_addr", 32'(pixel_addr), 32'h0000);
      check("fc_read", 32'(pixel_read), 32'h1);
      tick();
      check("fa_addr", 32'(pixel_addr), 32'h0001);
      check("fa_read", 32'(pixel_read), 32'h1);
      tick();
      check("ff_font", 32'(font_addr), 32'h20A);
      check("ff_read", 32'(pixel_read), 32'h0);
      tick();
      check("fcap_font", 32'(font_addr), 32'h20A);
      tick();
      seq = 32'h11EEEE11;
      for (int b = 0; b < 8; b++) begin
         pix(1'b1, c);
         check("first_cell", 32'(c), 32'(4'(seq >> (28 - 4 * b))));
      end

      // Blink / intensity
      row_addr = 3'd0;
      vram[14'h1000] = 8'h80; vram[14'h1001] = 8'h9F; font[{8'h80, 3'd0}] = 8'hFF;
      vram[14'h1002] = 8'h81; vram[14'h1003] = 8'h9F; font[{8'h81, 3'd0}] = 8'h00;
      blink_en = 1'b1; blink_phase = 1'b1;
      directed_cell("blink_on", 14'h1000, 32'h11111111);
      blink_phase = 1'b0;
      directed_cell("blink_off", 14'h1000, 32'hFFFFFFFF);
      blink_en = 1'b0;
      directed_cell("intensity", 14'h1002, 32'h99999999);

      // Random lines
      for (int k = 0; k < 4; k++) begin
         row_addr    = 3'($urandom_range(0, 7));
         blink_en    = 1'($urandom_range(0, 1));
         blink_phase = 1'($urandom_range(0, 1));
         run_line(int'($urandom_range(0, 8191)) * 2, 6);
      end

      // 80 cells wrapping past the top of VRAM
      row_addr = 3'($urandom_range(0, 7));
      blink_en = 1'b0;
      rd_q.delete();
      rec_on = 1'b1;
      run_line(16'h3FFC, 80);
      rec_on = 1'b0;
      check("wrap_nreads", 32'(rd_q.size() >= 160), 32'h1);
      for (int k = 0; k < 80; k++) begin
         if (rd_q.size() < 2) break;
         check("wrap_char_addr", 32'(rd_q.pop_front()), 32'((16'h3FFC + 2 * k) % 16384));
         check("wrap_attr_addr", 32'(rd_q.pop_front()), 32'((16'h3FFC + 2 * k) % 16384 + 1));
      end

      // display_enable gap mid-cell
      row_addr = 3'd5;
      vram[14'h2000] = 8'h55; vram[14'h2001] = 8'h4B; font[{8'h55, 3'd5}] = 8'hA6;
      line(14'h2000);
      repeat (4) tick();
      seq = 32'hB4B44BB4;
      for (int b = 0; b < 4; b++) begin
         pix(1'b1, c);
         check("gap_pre", 32'(c), 32'(4'(seq >> (28 - 4 * b))));
      end
      for (int b = 0; b < 3; b++) begin
         pix(1'b0, c);
         check("gap_blank", 32'(c), 32'h0);
      end
      for (int b = 4; b < 8; b++) begin
         pix(1'b1, c);
         check("gap_post", 32'(c), 32'(4'(seq >> (28 - 4 * b))));
      end

      // Underrun: pixel_en right after line_start
      vram[14'h2100] = 8'h12; vram[14'h2101] = 8'h2E; font[{8'h12, 3'd5}] = 8'hF0;
      line(14'h2100);
      pix(1'b1, c);
      check("ur_pix0", 32'(c), 32'h0);
      check("ur_flag", 32'(underrun), 32'h1);
      pix(1'b1, c);
      check("ur_pix1", 32'(c), 32'h0);
      seq = 32'hEEEE2222;
      for (int b = 0; b < 8; b++) begin
         pix(1'b1, c);
         check("ur_glyph", 32'(c), 32'(4'(seq >> (28 - 4 * b))));
      end
      ur_exp = 1'b1;
      run_line(int'($urandom_range(0, 8191)) * 2, 2);

      // Reset asserted during the attribute fetch of the prefetch
      line(14'h2000);
      repeat (4) tick();
      pix(1'b1, c);
      check("mid_pix", 32'(c), 32'hB);
      check("mid_read", 32'(pixel_read), 32'h1);
      check("mid_addr", 32'(pixel_addr), 32'h2003);
      reset_n = 1'b0;
      #1;
      check_zero("async_reset");
      tick();
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         pix(1'b1, c);
         check("idle_col", 32'(c), 32'h0);
         check("idle_read", 32'(pixel_read), 32'h0);
         check("idle_ur", 32'(underrun), 32'h0);
      end
      line(14'h0100);
      check("restart_read", 32'(pixel_read), 32'h1);
      check("restart_addr", 32'(pixel_addr), 32'h0100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
